// File: rtl/i2s_transmitter_if.sv
// Sample-in / I2S-out bundle shared by the transmitter and whatever feeds it.
// The sample source uses master; the transmitter uses slave.
interface i2s_transmitter_if;
    logic        ready_in;
    logic [15:0] left_in;
    logic [15:0] right_in;
    logic        i2s_bclk_out;
    logic        i2s_lrclk_out;
    logic        i2s_data_out;
    logic        frame_start_out;
    logic        underrun_out;
    logic        overflow_out;

    modport master (
        output ready_in, left_in, right_in,
        input  i2s_bclk_out, i2s_lrclk_out, i2s_data_out,
        input  frame_start_out, underrun_out, overflow_out
    );

    modport slave (
        input  ready_in, left_in, right_in,
        output i2s_bclk_out, i2s_lrclk_out, i2s_data_out,
        output frame_start_out, underrun_out, overflow_out
    );
endinterface

// File: rtl/i2s_transmitter.sv
// 16-bit stereo I2S transmitter: 64 BCLK per frame, 16-bit words in 32-bit slots,
// one pending sample buffered ahead of the frame being shifted out.
module i2s_transmitter #(
    parameter int BCLK_HALF = 12
) (
    input  logic              clk_in,
    input  logic              rst_in,
    i2s_transmitter_if.slave  bus
);
    localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);

    logic [DIV_W-1:0] r_div_cnt;
    logic             r_bclk;
    logic [5:0]       r_bit_cnt;
    logic             r_lrclk;
    logic             r_data;
    logic [15:0]      r_act_l;
    logic [15:0]      r_act_r;
    logic [15:0]      r_pend_l;
    logic [15:0]      r_pend_r;
    logic             r_pend_valid;
    logic             r_frame_start;
    logic             r_underrun;
    logic             r_overflow;

    logic             w_div_wrap;
    logic             w_fall;
    logic             w_frame_load;
    logic [5:0]       w_bit_next;
    logic [4:0]       w_k;
    logic [3:0]       w_idx;
    logic [15:0]      w_word;
    logic             w_data_next;

    assign w_div_wrap   = (r_div_cnt == DIV_LAST);
    assign w_fall       = w_div_wrap & r_bclk;
    assign w_frame_load = w_fall & (r_bit_cnt == 6'd63);
    assign w_bit_next   = r_bit_cnt + 6'd1;
    assign w_k          = w_bit_next[4:0];
    assign w_idx        = 4'(5'd16 - w_k);
    assign w_word       = w_bit_next[5] ? r_act_r : r_act_l;
    // Slot position 0 is the one-BCLK I2S delay; positions 17..31 pad the slot.
    assign w_data_next  = (w_k != 5'd0 && w_k <= 5'd16) ? w_word[w_idx] : 1'b0;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_div_cnt <= '0;
            r_bclk    <= 1'b0;
            r_bit_cnt <= 6'd63;
            r_lrclk   <= 1'b1;
            r_data    <= 1'b0;
        end else begin
            if (w_div_wrap) begin
                r_div_cnt <= '0;
                r_bclk    <= ~r_bclk;
            end else begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
            if (w_fall) begin
                r_bit_cnt <= w_bit_next;
                r_lrclk   <= w_bit_next[5];
                r_data    <= w_data_next;
            end
        end
    end

    // A sample arriving on the frame-load edge lands in pending after the old
    // pending has moved to active, so it is never counted as an overflow.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_act_l       <= '0;
            r_act_r       <= '0;
            r_pend_l      <= '0;
            r_pend_r      <= '0;
            r_pend_valid  <= 1'b0;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_frame_start <= w_frame_load;
            r_underrun    <= w_frame_load & ~r_pend_valid;
            r_overflow    <= bus.ready_in & r_pend_valid & ~w_frame_load;
            if (w_frame_load && r_pend_valid) begin
                r_act_l <= r_pend_l;
                r_act_r <= r_pend_r;
            end
            if (bus.ready_in) begin
                r_pend_l     <= bus.left_in;
                r_pend_r     <= bus.right_in;
                r_pend_valid <= 1'b1;
            end else if (w_frame_load) begin
                r_pend_valid <= 1'b0;
            end
        end
    end

    assign bus.i2s_bclk_out    = r_bclk;
    assign bus.i2s_lrclk_out   = r_lrclk;
    assign bus.i2s_data_out    = r_data;
    assign bus.frame_start_out = r_frame_start;
    assign bus.underrun_out    = r_underrun;
    assign bus.overflow_out    = r_overflow;
endmodule

// File: tb/tb_i2s_transmitter.sv
// Bench for i2s_transmitter: stimulus queues the expected frame contents, a
// monitor deserialises each frame from the I2S pins and compares it.
module tb_i2s_transmitter;
    logic clk_in = 1'b0;
    logic rst_in = 1'b0;

    i2s_transmitter_if bus();

    i2s_transmitter #(.BCLK_HALF(12)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
        logic        und;
    } exp_t;

    exp_t exp_q[$];
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int ovf_cnt = 0;
    int spurious = 0;
    int frames_checked = 0;

    logic        prev_bclk = 1'b0;
    logic        in_frame = 1'b0;
    logic        m_fall;
    int          bit_pos = 0;
    exp_t        cur;
    logic [63:0] dbits;
    logic [63:0] lbits;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end else begin
            $display("[TB] ok %s = %0h", name, act);
        end
    endtask

    task automatic compare_frame();
        logic [15:0] l = '0;
        logic [15:0] r = '0;
        int z = 0;
        for (int i = 1; i <= 16; i++) begin
            l = {l[14:0], dbits[i]};
            r = {r[14:0], dbits[32+i]};
        end
        for (int i = 0; i < 64; i++)
            if (!((i >= 1 && i <= 16) || (i >= 33 && i <= 48)) && dbits[i]) z++;
        check("frame_left", 64'(l), 64'(cur.l));
        check("frame_right", 64'(r), 64'(cur.r));
        check("frame_pad_bits", 64'(z), 64'd0);
        check("frame_lrclk", lbits, 64'hFFFF_FFFF_0000_0000);
        frames_checked++;
    endtask

    // Monitor: sample on the falling clk edge, one bit per observed BCLK fall.
    initial begin
        forever begin
            @(negedge clk_in);
            if (!rst_in) begin
                in_frame  = 1'b0;
                bit_pos   = 0;
                prev_bclk = bus.i2s_bclk_out;
            end else begin
                m_fall = prev_bclk && !bus.i2s_bclk_out;
                if (bus.overflow_out) ovf_cnt++;
                if (!m_fall && (bus.frame_start_out || bus.underrun_out)) spurious++;
                if (m_fall && bus.underrun_out && !bus.frame_start_out) spurious++;
                if (m_fall && bus.frame_start_out) begin
                    if (in_frame && bit_pos == 64) compare_frame();
                    if (exp_q.size() > 0) begin
                        cur = exp_q.pop_front();
                        in_frame = 1'b1;
                        check("frame_underrun", 64'(bus.underrun_out), 64'(cur.und));
                    end else begin
                        in_frame = 1'b0;
                    end
                    bit_pos = 0;
                end
                if (m_fall && in_frame && bit_pos < 64) begin
                    dbits[bit_pos] = bus.i2s_data_out;
                    lbits[bit_pos] = bus.i2s_lrclk_out;
                    bit_pos++;
                end
                prev_bclk = bus.i2s_bclk_out;
            end
        end
    end

    task automatic send(input logic [15:0] l, input logic [15:0] r);
        @(posedge clk_in); #1;
        bus.ready_in = 1'b1;
        bus.left_in  = l;
        bus.right_in = r;
        @(posedge clk_in); #1;
        bus.ready_in = 1'b0;
    endtask

    task automatic wait_frame(output int at);
        int n = 0;
        at = -1;
        while (n < 2000 && at < 0) begin
            @(posedge clk_in); #1;
            n++;
            if (bus.frame_start_out) at = cyc;
        end
        if (at < 0) begin
            tests++;
            fails++;
            $display("FAIL frame_timeout: no frame_start_out within %0d cycles", n);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bclk"}, 64'(bus.i2s_bclk_out), 64'd0);
        check({tag, "_lrclk"}, 64'(bus.i2s_lrclk_out), 64'd1);
        check({tag, "_data"}, 64'(bus.i2s_data_out), 64'd0);
        check({tag, "_frame_start"}, 64'(bus.frame_start_out), 64'd0);
        check({tag, "_underrun"}, 64'(bus.underrun_out), 64'd0);
        check({tag, "_overflow"}, 64'(bus.overflow_out), 64'd0);
    endtask

    // Called right after reset release: counts cycles to first BCLK rise and first frame load.
    task automatic measure_restart(input logic do_send, input logic [15:0] l,
                                   input logic [15:0] r, output int frame_at);
        int n = 0;
        int rise_n = -1;
        int frame_n = -1;
        frame_at = -1;
        while (n < 200 && frame_n < 0) begin
            @(posedge clk_in); #1;
            n++;
            if (do_send && n == 3) begin
                bus.ready_in = 1'b1;
                bus.left_in  = l;
                bus.right_in = r;
            end
            if (n == 4) bus.ready_in = 1'b0;
            if (rise_n < 0 && bus.i2s_bclk_out) rise_n = n;
            if (bus.frame_start_out) begin
                frame_n  = n;
                frame_at = cyc;
            end
        end
        check("first_bclk_rise_cycle", 64'(rise_n), 64'd12);
        check("first_frame_load_cycle", 64'(frame_n), 64'd24);
        check("first_frame_lrclk", 64'(bus.i2s_lrclk_out), 64'd0);
    endtask

    int f0, f1, f2, f3, f4, f5, f6, f7;

    initial begin
        bus.ready_in = 1'b0;
        bus.left_in  = '0;
        bus.right_in = '0;
        rst_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        check_reset_outputs("reset");

        // Idle start: silent frame with underrun.
        exp_q.push_back(exp_t'{16'h0000, 16'h0000, 1'b1});
        rst_in = 1'b1;
        measure_restart(1'b0, 16'h0, 16'h0, f0);

        // Two samples in one frame: second overwrites first.
        exp_q.push_back(exp_t'{16'h9ABC, 16'hDEF0, 1'b0});
        send(16'h1234, 16'h5678);
        send(16'h9ABC, 16'hDEF0);
        repeat (3) @(posedge clk_in);
        #1;
        check("overflow_count_after_double", 64'(ovf_cnt), 64'd1);

        wait_frame(f1);
        check("frame_period_cycles", 64'(f1 - f0), 64'd1536);

        // Pending 1111/2222, then 3333/4444 lands exactly on the next load edge.
        exp_q.push_back(exp_t'{16'h1111, 16'h2222, 1'b0});
        exp_q.push_back(exp_t'{16'h3333, 16'h4444, 1'b0});
        send(16'h1111, 16'h2222);
        while (cyc < f1 + 1535) begin
            @(posedge clk_in); #1;
        end
        bus.ready_in = 1'b1;
        bus.left_in  = 16'h3333;
        bus.right_in = 16'h4444;
        check("load_not_before_edge", 64'(bus.frame_start_out), 64'd0);
        @(posedge clk_in); #1;
        check("load_coincides_with_ready", 64'(bus.frame_start_out), 64'd1);
        bus.ready_in = 1'b0;
        f2 = cyc;

        wait_frame(f3);
        exp_q.push_back(exp_t'{16'h3333, 16'h4444, 1'b1});
        wait_frame(f4);
        check("overflow_count_after_coincident", 64'(ovf_cnt), 64'd1);

        // Abort mid-frame at bit 40 while BCLK is high.
        while (cyc < f4 + 972) begin
            @(posedge clk_in); #1;
        end
        check("bclk_high_before_abort", 64'(bus.i2s_bclk_out), 64'd1);
        check("lrclk_right_before_abort", 64'(bus.i2s_lrclk_out), 64'd1);
        rst_in = 1'b0;
        #1;
        check_reset_outputs("async_abort");
        repeat (3) @(posedge clk_in);
        #1;
        check("abort_hold_bclk", 64'(bus.i2s_bclk_out), 64'd0);

        // Sample before the first load after restart, then a repeated frame.
        exp_q.push_back(exp_t'{16'hA5C3, 16'h8001, 1'b0});
        exp_q.push_back(exp_t'{16'hA5C3, 16'h8001, 1'b1});
        rst_in = 1'b1;
        measure_restart(1'b1, 16'hA5C3, 16'h8001, f5);
        wait_frame(f6);
        wait_frame(f7);
        repeat (4) @(posedge clk_in);
        #1;

        check("overflow_count_final", 64'(ovf_cnt), 64'd1);
        check("stray_pulses", 64'(spurious), 64'd0);
        check("frames_compared", 64'(frames_checked), 64'd6);
        check("expect_queue_left", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/i2s_transmitter.md
I2S_TRANSMITTER -- requirements
Module: i2s_transmitter

Interface
REQ-001 SHALL have parameter BCLK_HALF, default 12, meaning clk_in cycles per i2s_bclk_out half-period (100 MHz -> 4.167 MHz BCLK).
REQ-002 SHALL have port clk_in, input, 1, the single system clock (100 MHz).
REQ-003 SHALL have port rst_in, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port ready_in, input, 1, one-cycle pulse marking a new stereo sample on left_in/right_in.
REQ-005 SHALL have port left_in, input, 16, signed left-channel sample (speaker path).
REQ-006 SHALL have port right_in, input, 16, signed right-channel sample.
REQ-007 SHALL have port i2s_bclk_out, output, 1, serial bit clock to the amplifier.
REQ-008 SHALL have port i2s_lrclk_out, output, 1, word select: 0 = left, 1 = right; equals BCLK/64.
REQ-009 SHALL have port i2s_data_out, output, 1, serial data, MSB first.
REQ-010 SHALL have port frame_start_out, output, 1, one-cycle pulse when a frame loads.
REQ-011 SHALL have port underrun_out, output, 1, one-cycle pulse when a frame loads with no pending sample.
REQ-012 SHALL have port overflow_out, output, 1, one-cycle pulse when a pending sample is overwritten.

Function
REQ-013 SHALL keep div_cnt (0..BCLK_HALF-1); at BCLK_HALF-1 toggle i2s_bclk_out and wrap to 0; otherwise increment.
REQ-014 SHALL define a "falling event" as the cycle in which i2s_bclk_out toggles 1->0; all serial outputs change only on falling events, registered.
REQ-015 SHALL keep 6-bit bit_cnt, advancing mod 64 on each falling event; 63 wraps to 0.
REQ-016 SHALL drive i2s_lrclk_out = bit_cnt[5] after each falling event.
REQ-017 SHALL, with k = bit_cnt[4:0] and word = active left (bit_cnt<32) or active right, drive i2s_data_out = word[16-k] for k in 1..16 and 0 for k = 0 and 17..31 (standard I2S one-BCLK MSB delay, 16 bits in 32-bit slot).
REQ-018 SHALL hold one pending stereo register plus pending_valid; ready_in captures left_in/right_in into pending and sets pending_valid.
REQ-019 SHALL, at the falling event where bit_cnt wraps 63->0 (frame load): if pending_valid, copy pending to active and clear pending_valid; else keep active unchanged (repeat last sample) and pulse underrun_out.
REQ-020 SHALL pulse frame_start_out in the clock cycle of every frame load.
REQ-021 SHALL, on simultaneous ready_in and frame load, move old pending (if valid) to active, store the new sample in pending with pending_valid=1; no overflow; underrun_out fires if old pending was empty.
REQ-022 SHALL, on ready_in with pending_valid=1 and no same-cycle frame load, overwrite pending and pulse overflow_out.
REQ-023 SHALL apply active-register updates only at frame load; left/right of a frame always come from the same accepted sample.
REQ-024 SHALL use word bits directly (two's complement, no sign conversion or scaling).

Reset
REQ-025 SHALL, while rst_in=0, force: div_cnt=0, bit_cnt=63, i2s_bclk_out=0, i2s_lrclk_out=1, i2s_data_out=0, active left/right=0, pending=0, pending_valid=0, all pulse outputs 0.
REQ-026 SHALL, after rst_in deasserts, produce the first BCLK rising edge after BCLK_HALF cycles and the first falling event (frame load, bit_cnt=0, lrclk->0) after 2*BCLK_HALF cycles.
REQ-027 SHALL, on reset asserted mid-frame, abort immediately to the REQ-025 state; a partial word is discarded, no pulse emitted.

Verification
REQ-028 Reset release, no ready_in, BCLK_HALF=12 -> bclk period 24 cycles, lrclk period 1536 cycles, data all 0, underrun_out pulse at cycle 24 and every 1536 cycles.
REQ-029 ready_in with left=16'hA5C3, right=16'h8001 before first frame load -> left slot bits 1..16 = 1010010111000011, right slot = 1000000000000001, other slot bits 0, no underrun.
REQ-030 No further ready_in after REQ-029 -> next frame repeats A5C3/8001 with underrun_out pulse.
REQ-031 Two ready_in pulses (1234/5678 then 9ABC/DEF0) within one frame -> overflow_out once, next frame sends 9ABC/DEF0.
REQ-032 ready_in coincident with frame-load cycle, pending holding 1111/2222, new 3333/4444 -> frame sends 1111/2222, next frame 3333/4444, no overflow or underrun.
REQ-033 rst_in low at bit_cnt=40 for 3 cycles -> outputs reach REQ-025 values asynchronously; restart timing matches REQ-026.
